// File: rtl/mac_lookup_hdr_parser.sv
// Header parser in front of the MAC CAM: extracts dst/src MAC and ingress port from the
// 64-bit packet stream, runs the lookup handshake and queues the returned dst_ports.
module mac_lookup_hdr_parser #(
    parameter int         NUM_OUTPUT_QUEUES   = 8,
    parameter int         NUM_IQ_BITS         = 3,
    parameter logic [7:0] IOQ_STAGE_NUM       = 8'hff,
    parameter int         RES_FIFO_DEPTH_BITS = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [63:0]                  in_data,
    input  logic [7:0]                   in_ctrl,
    input  logic                         in_wr,
    output logic                         parse_rdy,
    output logic [47:0]                  dst_mac,
    output logic [47:0]                  src_mac,
    output logic [NUM_IQ_BITS-1:0]       src_port,
    output logic                         lookup_req,
    input  logic                         lookup_ack,
    input  logic [NUM_OUTPUT_QUEUES-1:0] dst_ports,
    output logic [NUM_OUTPUT_QUEUES-1:0] res_ports,
    output logic                         res_vld,
    input  logic                         res_rd,
    output logic                         parse_err
);

    localparam int DEPTH = 2 ** RES_FIFO_DEPTH_BITS;
    localparam int PW    = RES_FIFO_DEPTH_BITS;
    localparam int CW    = RES_FIFO_DEPTH_BITS + 1;

    localparam logic [1:0] HDRS    = 2'd0;
    localparam logic [1:0] WORD1   = 2'd1;
    localparam logic [1:0] WORD2   = 2'd2;
    localparam logic [1:0] PAYLOAD = 2'd3;

    logic [1:0]                   state_q, state_d;
    logic [47:0]                  dst_mac_q, dst_mac_d;
    logic [47:0]                  src_mac_q, src_mac_d;
    logic [NUM_IQ_BITS-1:0]       src_port_q, src_port_d;
    logic                         lookup_req_q, lookup_req_d;
    logic                         pend_q, pend_d;
    logic                         parse_err_q, parse_err_d;
    logic                         word2_ok;
    logic [NUM_OUTPUT_QUEUES-1:0] mem_q [DEPTH];
    logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                count_q;
    logic                         lookup_busy, push, pop, do_push;

    // pend_q holds a lookup that is waiting for a stale lookup_ack to drop first
    assign lookup_busy = lookup_req_q | pend_q;
    assign parse_rdy   = (state_q == HDRS) && !lookup_busy && (count_q != CW'(DEPTH));
    assign push        = lookup_req_q & lookup_ack;
    assign pop         = res_rd & (count_q != '0);
    assign do_push     = push & ((count_q != CW'(DEPTH)) | pop);

    always_comb begin
        state_d     = state_q;
        dst_mac_d   = dst_mac_q;
        src_mac_d   = src_mac_q;
        src_port_d  = src_port_q;
        parse_err_d = 1'b0;
        word2_ok    = 1'b0;
        if (in_wr) begin
            case (state_q)
                HDRS: begin
                    if (!parse_rdy) begin
                        parse_err_d = 1'b1;
                    end else if (in_ctrl == IOQ_STAGE_NUM) begin
                        src_port_d = in_data[16+NUM_IQ_BITS-1:16];
                        state_d    = WORD1;
                    end else if (in_ctrl == 8'h00) begin
                        // first data word with no IOQ header: keep old src_port, flag it
                        dst_mac_d          = in_data[63:16];
                        src_mac_d[47:32]   = in_data[15:0];
                        parse_err_d        = 1'b1;
                        state_d            = WORD2;
                    end
                end
                WORD1: begin
                    if (in_ctrl == 8'h00) begin
                        dst_mac_d        = in_data[63:16];
                        src_mac_d[47:32] = in_data[15:0];
                        state_d          = WORD2;
                    end
                end
                WORD2: begin
                    if (in_ctrl != 8'h00) begin
                        parse_err_d = 1'b1;
                        state_d     = HDRS;
                    end else begin
                        src_mac_d[31:0] = in_data[63:32];
                        word2_ok        = 1'b1;
                        state_d         = PAYLOAD;
                    end
                end
                default: begin
                    if (in_ctrl != 8'h00) begin
                        state_d = HDRS;
                    end
                end
            endcase
        end
    end

    always_comb begin
        lookup_req_d = lookup_req_q;
        pend_d       = pend_q;
        if (push) begin
            lookup_req_d = 1'b0;
        end
        if (word2_ok || pend_q) begin
            if (!lookup_ack) begin
                lookup_req_d = 1'b1;
                pend_d       = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HDRS;
            dst_mac_q    <= '0;
            src_mac_q    <= '0;
            src_port_q   <= '0;
            lookup_req_q <= 1'b0;
            pend_q       <= 1'b0;
            parse_err_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            dst_mac_q    <= dst_mac_d;
            src_mac_q    <= src_mac_d;
            src_port_q   <= src_port_d;
            lookup_req_q <= lookup_req_d;
            pend_q       <= pend_d;
            parse_err_q  <= parse_err_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= dst_ports;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign dst_mac    = dst_mac_q;
    assign src_mac    = src_mac_q;
    assign src_port   = src_port_q;
    assign lookup_req = lookup_req_q;
    assign parse_err  = parse_err_q;
    assign res_vld    = (count_q != '0);
    assign res_ports  = res_vld ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_mac_lookup_hdr_parser.sv
// Self-checking bench for mac_lookup_hdr_parser: table of packets plus hand-written
// sequences for FIFO full, push/pop collision and reset during a pending lookup.
module tb_mac_lookup_hdr_parser;

    localparam logic [7:0] IOQ = 8'hff;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        parse_rdy;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [2:0]  src_port;
    logic        lookup_req;
    logic        lookup_ack;
    logic [7:0]  dst_ports;
    logic [7:0]  res_ports;
    logic        res_vld;
    logic        res_rd;
    logic        parse_err;

    mac_lookup_hdr_parser dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_wr      (in_wr),
        .parse_rdy  (parse_rdy),
        .dst_mac    (dst_mac),
        .src_mac    (src_mac),
        .src_port   (src_port),
        .lookup_req (lookup_req),
        .lookup_ack (lookup_ack),
        .dst_ports  (dst_ports),
        .res_ports  (res_ports),
        .res_vld    (res_vld),
        .res_rd     (res_rd),
        .parse_err  (parse_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          useIoq;
        bit          extraHdr;
        logic [2:0]  port;
        logic [47:0] dst;
        logic [47:0] src;
        bit          runt;
        logic [7:0]  ports;
        int          ackDelay;
        int          expErr;
        logic [2:0]  expPort;
    } vec_t;

    vec_t       vecs[5];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] expQ[$];

    int   reqRises = 0;
    int   reqRun = 0;
    int   lastReqLen = 0;
    int   errPulses = 0;
    logic vldAtFall = 1'b0;
    logic prevReq = 1'b0;

    int         ackDelay = 0;
    logic [7:0] respPorts = 8'h00;
    bit         autoAck = 1'b1;
    int         waitCnt = 0;

    // lookup/err monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            reqRun  = 0;
            prevReq = 1'b0;
        end else begin
            if (lookup_req && !prevReq) reqRises++;
            if (lookup_req) reqRun++;
            if (!lookup_req && prevReq) begin
                lastReqLen = reqRun;
                reqRun     = 0;
                vldAtFall  = res_vld;
            end
            if (parse_err) errPulses++;
            prevReq = lookup_req;
        end
    end

    // CAM responder: acks ackDelay cycles after the request is seen, holds until req drops
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!autoAck) begin
                waitCnt = 0;
            end else if (lookup_ack && !lookup_req) begin
                lookup_ack = 1'b0;
                waitCnt    = 0;
            end else if (lookup_req && !lookup_ack) begin
                if (waitCnt == ackDelay) begin
                    lookup_ack = 1'b1;
                    dst_ports  = respPorts;
                end else begin
                    waitCnt++;
                end
            end else if (!lookup_req) begin
                waitCnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mkVec(input bit useIoq, input bit extraHdr, input logic [2:0] port,
                                   input logic [47:0] dst, input logic [47:0] src, input bit runt,
                                   input logic [7:0] ports, input int dly, input int expErr,
                                   input logic [2:0] expPort);
        vec_t v;
        v.useIoq = useIoq; v.extraHdr = extraHdr; v.port = port; v.dst = dst; v.src = src;
        v.runt = runt; v.ports = ports; v.ackDelay = dly; v.expErr = expErr; v.expPort = expPort;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sendWord(input logic [63:0] d, input logic [7:0] c);
        in_data = d;
        in_ctrl = c;
        in_wr   = 1'b1;
        @(posedge clk);
        #1;
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [63:0] hdr;
        hdr        = '0;
        hdr[18:16] = v.port;
        respPorts  = v.ports;
        ackDelay   = v.ackDelay;
        if (!v.runt) expQ.push_back(v.ports);
        if (v.extraHdr) sendWord(64'h0000_0000_0000_1234, 8'h40);
        if (v.useIoq) sendWord(hdr, IOQ);
        sendWord({v.dst, v.src[47:32]}, 8'h00);
        sendWord({v.src[31:0], 32'h5A5A_5A5A}, v.runt ? 8'h01 : 8'h00);
        if (!v.runt) begin
            sendWord(64'hDEAD_BEEF_0000_0001, 8'h00);
            sendWord(64'hC0FF_EE00_0000_0002, 8'h80);
        end
    endtask

    task automatic waitReady(input string name);
        int n;
        n = 0;
        while (!parse_rdy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, 64'(parse_rdy), 64'd1);
    endtask

    task automatic waitLookupDone(input string name, input int rises0, input int nExp);
        int  n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            done = (reqRises == rises0 + nExp) && !lookup_req && !lookup_ack;
            if (!done) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput(name, 64'(done), 64'd1);
    endtask

    task automatic drainFifo(input string name);
        int n;
        logic [7:0] exp;
        n = 0;
        while (res_vld && n < 8) begin
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                checkOutput({name, "_resPorts"}, 64'(res_ports), 64'(exp));
            end else begin
                checkOutput({name, "_spurious"}, 64'(res_vld), 64'd0);
            end
            res_rd = 1'b1;
            @(posedge clk);
            #1;
            res_rd = 1'b0;
            n++;
        end
        checkOutput({name, "_queueLeft"}, 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        int rises0;
        int err0;
        int n;
        logic [7:0] exp;
        vec_t p;

        vecs[0] = mkVec(1, 0, 3'd3, 48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 0, 8'h10, 2, 0, 3'd3);
        vecs[1] = mkVec(1, 1, 3'd5, 48'h0A0B_0C0D_0E0F, 48'h1234_5678_9ABC, 0, 8'h81, 0, 0, 3'd5);
        vecs[2] = mkVec(1, 0, 3'd2, 48'hFFEE_DDCC_BBAA, 48'h0102_0304_0506, 1, 8'h00, 0, 1, 3'd2);
        vecs[3] = mkVec(0, 0, 3'd7, 48'h5555_6666_7777, 48'h8888_9999_AAAA, 0, 8'h04, 1, 1, 3'd2);
        vecs[4] = mkVec(1, 0, 3'd7, 48'h0000_0000_0001, 48'hFFFF_FFFF_FFFE, 0, 8'hFF, 4, 0, 3'd7);

        reset = 1'b1; in_data = '0; in_ctrl = '0; in_wr = 1'b0;
        lookup_ack = 1'b0; dst_ports = '0; res_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_lookupReq", 64'(lookup_req), 64'd0);
        checkOutput("rst_parseErr", 64'(parse_err), 64'd0);
        checkOutput("rst_dstMac", 64'(dst_mac), 64'd0);
        checkOutput("rst_srcMac", 64'(src_mac), 64'd0);
        checkOutput("rst_srcPort", 64'(src_port), 64'd0);
        checkOutput("rst_resVld", 64'(res_vld), 64'd0);
        checkOutput("rst_resPorts", 64'(res_ports), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_parseRdy", 64'(parse_rdy), 64'd1);

        for (int i = 0; i < 5; i++) begin
            rises0 = reqRises;
            err0   = errPulses;
            waitReady($sformatf("vec%0d_ready", i));
            applyStimulus(vecs[i]);
            waitLookupDone($sformatf("vec%0d_done", i), rises0, vecs[i].runt ? 0 : 1);
            checkOutput($sformatf("vec%0d_reqRises", i), 64'(reqRises - rises0), vecs[i].runt ? 64'd0 : 64'd1);
            checkOutput($sformatf("vec%0d_parseErr", i), 64'(errPulses - err0), 64'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d_dstMac", i), 64'(dst_mac), 64'(vecs[i].dst));
            checkOutput($sformatf("vec%0d_srcPort", i), 64'(src_port), 64'(vecs[i].expPort));
            if (!vecs[i].runt) begin
                checkOutput($sformatf("vec%0d_srcMac", i), 64'(src_mac), 64'(vecs[i].src));
                checkOutput($sformatf("vec%0d_reqLen", i), 64'(lastReqLen), 64'(vecs[i].ackDelay + 1));
                checkOutput($sformatf("vec%0d_vldAfterAck", i), 64'(vldAtFall), 64'd1);
            end else begin
                checkOutput($sformatf("vec%0d_runtEmpty", i), 64'(res_vld), 64'd0);
            end
            drainFifo($sformatf("vec%0d", i));
        end

        // FIFO full: two results, no reads
        p = mkVec(1, 0, 3'd6, 48'h0101_0101_0101, 48'h0202_0202_0202, 0, 8'h21, 0, 0, 3'd6);
        waitReady("full_ready1");
        rises0 = reqRises;
        applyStimulus(p);
        waitLookupDone("full_done1", rises0, 1);
        checkOutput("full_rdyAfterOne", 64'(parse_rdy), 64'd1);
        p.ports = 8'h22;
        rises0 = reqRises;
        applyStimulus(p);
        waitLookupDone("full_done2", rises0, 1);
        checkOutput("full_rdyLow", 64'(parse_rdy), 64'd0);
        err0 = errPulses;
        sendWord(64'h0000_0000_0001_0000, IOQ);
        @(posedge clk);
        #1;
        checkOutput("full_violationErr", 64'(errPulses - err0), 64'd1);
        checkOutput("full_violationIgnored", 64'(src_port), 64'd6);
        exp = expQ.pop_front();
        checkOutput("full_head", 64'(res_ports), 64'(exp));
        res_rd = 1'b1;
        @(posedge clk);
        #1;
        res_rd = 1'b0;
        checkOutput("full_rdyRestored", 64'(parse_rdy), 64'd1);

        // pop on the same edge as a push with one entry queued
        p = mkVec(1, 0, 3'd1, 48'h0303_0303_0303, 48'h0404_0404_0404, 0, 8'h33, 3, 0, 3'd1);
        rises0 = reqRises;
        applyStimulus(p);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!lookup_ack && n < 20);
        checkOutput("simul_ackSeen", 64'(lookup_ack), 64'd1);
        exp = expQ.pop_front();
        checkOutput("simul_oldHead", 64'(res_ports), 64'(exp));
        res_rd = 1'b1;
        @(posedge clk);
        #1;
        res_rd = 1'b0;
        checkOutput("simul_vld", 64'(res_vld), 64'd1);
        checkOutput("simul_newHead", 64'(res_ports), 64'h33);
        waitLookupDone("simul_done", rises0, 1);
        drainFifo("simul");
        checkOutput("simul_countOne", 64'(res_vld), 64'd0);

        // reset while a lookup is pending, ack held high across release
        autoAck = 1'b0;
        p = mkVec(1, 0, 3'd5, 48'h0505_0505_0505, 48'h0606_0606_0606, 0, 8'h55, 0, 0, 3'd5);
        applyStimulus(p);
        void'(expQ.pop_back());
        checkOutput("rstLk_reqHigh", 64'(lookup_req), 64'd1);
        lookup_ack = 1'b1;
        dst_ports  = 8'h55;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstLk_reqDropAsync", 64'(lookup_req), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstLk_reqLow", 64'(lookup_req), 64'd0);
        checkOutput("rstLk_noPush", 64'(res_vld), 64'd0);
        checkOutput("rstLk_rdy", 64'(parse_rdy), 64'd1);
        checkOutput("rstLk_srcPort", 64'(src_port), 64'd0);
        p = mkVec(1, 0, 3'd4, 48'h0707_0707_0707, 48'h0808_0808_0808, 0, 8'h66, 1, 0, 3'd4);
        rises0 = reqRises;
        applyStimulus(p);
        checkOutput("rstLk_staleAckNoReq", 64'(lookup_req), 64'd0);
        checkOutput("rstLk_staleAckNoPush", 64'(res_vld), 64'd0);
        checkOutput("rstLk_pendingRdy", 64'(parse_rdy), 64'd0);
        lookup_ack = 1'b0;
        autoAck    = 1'b1;
        waitLookupDone("rstLk_done", rises0, 1);
        checkOutput("rstLk_srcPortNew", 64'(src_port), 64'd4);
        checkOutput("rstLk_dstMacNew", 64'(dst_mac), 64'h0707_0707_0707);
        drainFifo("rstLk");
        checkOutput("final_empty", 64'(res_vld), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
